// File: rtl/bstream_avg_n.sv
// Multi-channel bitstream averager: folds N_IN unary bitstreams into one scaled-sum stream
// and publishes the ones count of each completed window of enabled cycles.
module bstream_avg_n #(
    parameter int unsigned N_IN     = 2,
    parameter int unsigned WIN_LOG2 = 4,
    localparam int unsigned MEAN_W  = $clog2(N_IN * (1 << WIN_LOG2) + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clear_i,
    input  logic [N_IN-1:0]   x_i,
    output logic              y_o,
    output logic [MEAN_W-1:0] mean_o,
    output logic              mean_valid_o
);

    localparam int unsigned AccW = $clog2(N_IN);
    localparam int unsigned SumW = $clog2(2 * N_IN);
    localparam int unsigned PcW  = $clog2(N_IN + 1);

    logic [AccW-1:0]     acc_q, acc_d;
    logic [WIN_LOG2-1:0] wcnt_q, wcnt_d;
    logic [MEAN_W-1:0]   ones_q, ones_d;
    logic [MEAN_W-1:0]   mean_q, mean_d;
    logic                y_q, y_d;
    logic                mean_valid_q, mean_valid_d;

    logic [PcW-1:0]  pc;
    logic [SumW-1:0] sum;
    logic [MEAN_W-1:0] ones_inc;

    always_comb begin
        pc = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            pc = pc + PcW'(x_i[i]);
        end
    end

    // Sum is one bit wider than the accumulator so acc + pc never wraps.
    assign sum      = SumW'(acc_q) + SumW'(pc);
    assign ones_inc = ones_q + MEAN_W'(pc);

    always_comb begin
        acc_d        = acc_q;
        wcnt_d       = wcnt_q;
        ones_d       = ones_q;
        mean_d       = mean_q;
        y_d          = 1'b0;
        mean_valid_d = 1'b0;
        if (clear_i) begin
            acc_d  = '0;
            wcnt_d = '0;
            ones_d = '0;
        end else if (en_i) begin
            if (sum >= SumW'(N_IN)) begin
                acc_d = AccW'(sum - SumW'(N_IN));
                y_d   = 1'b1;
            end else begin
                acc_d = AccW'(sum);
            end
            wcnt_d = wcnt_q + WIN_LOG2'(1);
            if (&wcnt_q) begin
                mean_d       = ones_inc;
                mean_valid_d = 1'b1;
                ones_d       = '0;
            end else begin
                ones_d = ones_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q        <= '0;
            wcnt_q       <= '0;
            ones_q       <= '0;
            mean_q       <= '0;
            y_q          <= 1'b0;
            mean_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            wcnt_q       <= wcnt_d;
            ones_q       <= ones_d;
            mean_q       <= mean_d;
            y_q          <= y_d;
            mean_valid_q <= mean_valid_d;
        end
    end

    assign y_o          = y_q;
    assign mean_o       = mean_q;
    assign mean_valid_o = mean_valid_q;

endmodule

// File: tb/tb_bstream_avg_n.sv
// Directed bench for bstream_avg_n with N_IN=2, WIN_LOG2=4 (16-cycle windows).
module tb_bstream_avg_n;

    localparam int unsigned N_IN     = 2;
    localparam int unsigned WIN_LOG2 = 4;
    localparam int unsigned MEAN_W   = $clog2(N_IN * (1 << WIN_LOG2) + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en = 1'b0;
    logic              clear = 1'b0;
    logic [N_IN-1:0]   x = '0;
    logic              y;
    logic [MEAN_W-1:0] mean;
    logic              mean_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bstream_avg_n #(
        .N_IN    (N_IN),
        .WIN_LOG2(WIN_LOG2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .clear_i     (clear),
        .x_i         (x),
        .y_o         (y),
        .mean_o      (mean),
        .mean_valid_o(mean_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input logic e, input logic c, input logic [N_IN-1:0] xv);
        @(negedge clk);
        en    = e;
        clear = c;
        x     = xv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        #1;
        check("rst y", 32'(y), 0);
        check("rst mean", 32'(mean), 0);
        check("rst mv", 32'(mean_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // x=11 constant: y=1 every cycle, mean 32 every 16th cycle.
        for (int k = 1; k <= 32; k++) begin
            cyc(1'b1, 1'b0, 2'b11);
            check("x11 y", 32'(y), 1);
            check("x11 mv", 32'(mean_valid), (k % 16 == 0) ? 1 : 0);
            if (k % 16 == 0) check("x11 mean", 32'(mean), 32);
        end

        // x=01 constant: y alternates 0,1 starting at 0; mean 16.
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 2'b01);
            check("x01 y", 32'(y), (k % 2 == 0) ? 1 : 0);
            check("x01 mv", 32'(mean_valid), (k == 16) ? 1 : 0);
            if (k == 16) check("x01 mean", 32'(mean), 16);
        end

        // x=11 with en toggling: 16th enabled cycle is clock 31.
        for (int k = 1; k <= 32; k++) begin
            cyc((k % 2 == 1), 1'b0, 2'b11);
            check("tog y", 32'(y), (k % 2 == 1) ? 1 : 0);
            check("tog mv", 32'(mean_valid), (k == 31) ? 1 : 0);
            if (k == 31) check("tog mean", 32'(mean), 32);
        end

        // x=00: y stays 0, strobe still fires with mean 0.
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 2'b00);
            check("x00 y", 32'(y), 0);
            check("x00 mv", 32'(mean_valid), (k == 16) ? 1 : 0);
            if (k == 16) check("x00 mean", 32'(mean), 0);
        end

        // 10 cycles of x=01, clear (x=11 discarded), then 16 cycles of x=11.
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 1'b0, 2'b01);
            check("pre-clr mv", 32'(mean_valid), 0);
        end
        cyc(1'b1, 1'b1, 2'b11);
        check("clr y", 32'(y), 0);
        check("clr mv", 32'(mean_valid), 0);
        check("clr mean held", 32'(mean), 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 2'b11);
            check("post-clr y", 32'(y), 1);
            check("post-clr mv", 32'(mean_valid), (k == 16) ? 1 : 0);
            if (k == 16) check("post-clr mean", 32'(mean), 32);
        end

        // Leave acc=1, clear, then x=01 must restart with y=0.
        cyc(1'b1, 1'b0, 2'b01);
        check("acc1 y", 32'(y), 0);
        cyc(1'b1, 1'b1, 2'b01);
        check("acc clr y", 32'(y), 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 2'b01);
            check("restart y", 32'(y), (k % 2 == 0) ? 1 : 0);
            check("restart mv", 32'(mean_valid), (k == 16) ? 1 : 0);
            if (k == 16) check("restart mean", 32'(mean), 16);
        end

        // Asynchronous reset mid-window while mean=16 is held and y=1.
        for (int k = 1; k <= 6; k++) cyc(1'b1, 1'b0, 2'b01);
        check("pre-rst y", 32'(y), 1);
        check("pre-rst mean", 32'(mean), 16);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst y", 32'(y), 0);
        check("async rst mean", 32'(mean), 0);
        check("async rst mv", 32'(mean_valid), 0);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 2'b11);
            check("post-rst y", 32'(y), 1);
            check("post-rst mv", 32'(mean_valid), (k == 16) ? 1 : 0);
            if (k == 16) check("post-rst mean", 32'(mean), 32);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bstream_avg_n.md
BSTREAM_AVG_N -- requirements
Module: bstream_avg_n

Interface
REQ-001 Parameter N_IN, default 2, meaning number of input bitstream channels, legal 2..8.
REQ-002 Parameter WIN_LOG2, default 4, meaning log2 of the statistics window length in enabled cycles, legal 1..12.
REQ-003 Derived MEAN_W = clog2(N_IN*2^WIN_LOG2 + 1) SHALL size the mean output.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  sample enable; x consumed only on cycles with en=1.
REQ-007 clear  in  1  synchronous restart of accumulator and window.
REQ-008 x  in  N_IN  one bit per channel bitstream.
REQ-009 y  out  1  registered scaled-sum output bitstream.
REQ-010 mean  out  MEAN_W  ones count of the last completed window.
REQ-011 mean_valid  out  1  one-cycle strobe, mean updated.

Function
REQ-012 pc = popcount(x), range 0..N_IN, SHALL be computed combinationally each cycle.
REQ-013 Accumulator acc, range 0..N_IN-1, width clog2(N_IN); s = acc + pc, range 0..2*N_IN-1, computed without overflow.
REQ-014 On en=1, clear=0: if s >= N_IN then acc <= s - N_IN and y <= 1, else acc <= s and y <= 0.
REQ-015 On en=0, clear=0: acc holds, y <= 0.
REQ-016 y SHALL reflect the x of the previous cycle (latency 1); long-run density of y equals mean input density (sum/N_IN) with error bounded by (N_IN-1)/N_IN ones total, no drift.
REQ-017 Window counter wcnt (WIN_LOG2 bits) SHALL increment once per en=1 cycle and wrap from 2^WIN_LOG2-1 to 0.
REQ-018 Ones counter ones (MEAN_W bits) SHALL add pc on each en=1 cycle; max value N_IN*2^WIN_LOG2 never overflows.
REQ-019 On the en=1 cycle where wcnt = 2^WIN_LOG2-1: mean <= ones + pc, mean_valid <= 1, ones <= 0, wcnt <= 0.
REQ-020 mean_valid SHALL be 1 for exactly one cycle per completed window, 0 otherwise; mean holds between strobes.
REQ-021 en=0 cycles SHALL not advance wcnt or ones; windows count enabled cycles only.
REQ-022 clear=1 (priority over en) SHALL set acc, wcnt, ones to 0, y to 0, mean_valid to 0; mean retains its last value; x on that cycle is discarded.
REQ-023 clear asserted on the would-be final window cycle SHALL suppress the strobe; no partial mean is ever published.

Reset
REQ-024 rst_n=0 SHALL immediately and asynchronously force acc=0, wcnt=0, ones=0, y=0, mean=0, mean_valid=0.
REQ-025 Reset release SHALL be followed by normal operation on the first clk edge with rst_n=1; reset mid-window discards the partial window.

Verification (N_IN=2, WIN_LOG2=4)
REQ-026 x=11, en=1 constant after reset -> y=1 from 2nd cycle on; mean=32 with mean_valid on the 16th enabled cycle's following cycle, every 16 cycles.
REQ-027 x=01 constant, en=1 -> y sequence 0,1,0,1,... starting with y=0; mean=16 each window.
REQ-028 x=00 constant -> y=0 always; mean=0, mean_valid still strobes every 16 cycles.
REQ-029 x=11 with en toggling 1/0 -> y=1 only after enabled cycles, 0 after disabled ones; mean_valid every 32 clocks, mean=32.
REQ-030 x=01 for 10 enabled cycles then clear=1 one cycle, then x=11 for 16 cycles -> acc restarted, no strobe at old boundary, mean=32 after the 16 post-clear cycles.
REQ-031 rst_n pulsed low asynchronously mid-window with mean=16 held -> y, mean, mean_valid read 0 before the next clk edge; next window starts fresh.
